dec_stream: RTL and testbench

Registered, parametrised successor to the combinational binary-to-one-hot `decoder`. It accepts an index `N` over a valid/ready input handshake and emits decoded words over a valid/ready output handshake. Four modes are supported: one-hot, thermometer, and forward or reverse walking-one scan, where a scan produces N+1 output beats. It sits between index-producing control logic (arbiters, address generators) and select/enable fabrics that need registered, back-pressurable decode.

---
 rtl/dec_stream.sv | 98 +++++++++
 tb/tb_dec_stream.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dec_stream.sv
// dec_stream: registered valid/ready index decoder with one-hot, thermometer and walking-one scan modes
module dec_stream #(
    parameter int N_IN = 3,
    parameter int OUT = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] N,
    input  logic [1:0]      mode,
    output logic [OUT-1:0]  out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            out_err
);
    typedef enum logic {IDLE, EMIT} state_t;
    state_t state_q, state_d;
    logic [N_IN-1:0] n_q, n_d, cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic [OUT-1:0] out_q, out_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, out_err_q, out_err_d;
    logic xfer, fin, acc;
    logic [OUT+1:0] first, next;

    // Packs {err, last, word} for beat position c of a request (m, n).
    function automatic logic [OUT+1:0] beat(input logic [1:0] m, input logic [N_IN-1:0] n, input logic [N_IN-1:0] c);
        logic [OUT:0] one, th;
        logic [OUT-1:0] w;
        logic e, l;
        e = 32'(n) >= OUT;
        one = (OUT+1)'(1) << (m == 2'd3 ? n - c : m == 2'd2 ? c : n);
        th = (one << 1) - (OUT+1)'(1);
        w = e ? '0 : m == 2'd1 ? th[OUT-1:0] : one[OUT-1:0];
        l = e || !m[1] || c == n;
        return {e, l, w};
    endfunction

    always_comb begin
        xfer = out_valid_q && out_ready;
        fin = xfer && out_last_q;
        in_ready = state_q == IDLE || fin;
        acc = in_valid && in_ready;
        first = beat(mode, N, '0);
        next = beat(mode_q, n_q, N_IN'(cnt_q + 1));
        state_d = state_q;
        n_d = n_q;
        mode_d = mode_q;
        cnt_d = cnt_q;
        out_d = out_q;
        out_valid_d = out_valid_q;
        out_last_d = out_last_q;
        out_err_d = out_err_q;
        if (acc) begin
            state_d = EMIT;
            n_d = N;
            mode_d = mode;
            cnt_d = '0;
            {out_err_d, out_last_d, out_d} = first;
            out_valid_d = 1'b1;
        end else if (fin) begin
            state_d = IDLE;
            {out_err_d, out_last_d, out_d} = '0;
            out_valid_d = 1'b0;
        end else if (xfer) begin
            cnt_d = N_IN'(cnt_q + 1);
            {out_err_d, out_last_d, out_d} = next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q <= '0;
            mode_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            mode_q <= mode_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q <= out_last_d;
            out_err_q <= out_err_d;
        end
    end

    assign out = out_q;
    assign out_valid = out_valid_q;
    assign out_last = out_last_q;
    assign out_err = out_err_q;
endmodule

// File: tb/tb_dec_stream.sv
// tb_dec_stream: scoreboard bench for dec_stream with an 8-wide and a 6-wide instance
module tb_dec_stream;
    logic clk, rst, iv, iv6, out_ready, tog;
    logic [2:0] N;
    logic [1:0] mode;
    logic in_ready, out_valid, out_last, out_err;
    logic in_ready6, out_valid6, out_last6, out_err6;
    logic [7:0] out;
    logic [5:0] out6;
    logic [9:0] q8[$], q6[$];
    int checks = 0, fails = 0, pops8 = 0;

    dec_stream #(.N_IN(3)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(in_ready), .N(N), .mode(mode),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_err(out_err)
    );

    dec_stream #(.N_IN(3), .OUT(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(in_ready6), .N(N), .mode(mode),
        .out(out6), .out_valid(out_valid6), .out_ready(out_ready), .out_last(out_last6), .out_err(out_err6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected beats as {err, last, word}, built independently per mode.
    task automatic push(input bit sel, input logic [1:0] m, input int n);
        int w = sel ? 6 : 8;
        logic [9:0] e;
        if (n >= w) begin
            e = 10'h200 | 10'h100;
            if (sel) q6.push_back(e); else q8.push_back(e);
        end else if (m < 2) begin
            e = {2'b01, m == 2'd0 ? 8'(1 << n) : 8'((1 << (n + 1)) - 1)};
            if (sel) q6.push_back(e); else q8.push_back(e);
        end else begin
            for (int i = 0; i <= n; i++) begin
                e = {1'b0, i == n, m == 2'd2 ? 8'(1 << i) : 8'(1 << (n - i))};
                if (sel) q6.push_back(e); else q8.push_back(e);
            end
        end
    endtask

    task automatic send(input bit sel, input logic [1:0] m, input int n);
        bit ok = 0;
        mode = m;
        N = 3'(n);
        if (sel) iv6 = 1'b1; else iv = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = sel ? in_ready6 : in_ready;
            @(posedge clk);
        end
        if (ok) push(sel, m, n); else check("accept_timeout", 0, 1);
        #1;
        iv = 1'b0;
        iv6 = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (q8.size() != 0 || q6.size() != 0); k++) @(posedge clk);
        if (q8.size() != 0 || q6.size() != 0) check("drain_timeout", 0, 1);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = tog ? !out_ready : 1'b1;
        end
    end

    always @(negedge clk) if (!rst) begin
        check("valid", out_valid, q8.size() != 0);
        if (q8.size() != 0 && out_valid) begin
            check("beat", {out_err, out_last, out}, q8[0]);
            check("in_ready", in_ready, out_ready && q8[0][8]);
            if (out_ready) begin
                void'(q8.pop_front());
                pops8++;
            end
        end else check("in_ready_idle", in_ready, 1);
    end

    always @(negedge clk) if (!rst) begin
        check("valid6", out_valid6, q6.size() != 0);
        if (q6.size() != 0 && out_valid6) begin
            check("beat6", {out_err6, out_last6, 2'b00, out6}, q6[0]);
            check("in_ready6", in_ready6, out_ready && q6[0][8]);
            if (out_ready) void'(q6.pop_front());
        end else check("in_ready6_idle", in_ready6, 1);
    end

    initial begin
        int p0;
        rst = 1'b1;
        iv = 1'b1;
        iv6 = 1'b1;
        N = 3'd3;
        mode = 2'd0;
        tog = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("rst_valid", out_valid, 0);
            check("rst_out", out, 0);
            check("rst_valid6", out_valid6, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        iv = 1'b0;
        iv6 = 1'b0;
        for (int n = 0; n < 8; n++) send(0, 2'd0, n);
        send(0, 2'd1, 5);
        send(0, 2'd1, 0);
        send(0, 2'd1, 7);
        drain();
        tog = 1'b1;
        send(0, 2'd2, 3);
        drain();
        tog = 1'b0;
        send(0, 2'd3, 2);
        send(0, 2'd0, 6);
        drain();
        send(1, 2'd2, 7);
        send(1, 2'd0, 6);
        send(1, 2'd1, 5);
        send(1, 2'd3, 5);
        drain();
        repeat (2) @(posedge clk);
        #1;
        p0 = pops8;
        send(0, 2'd2, 5);
        for (int k = 0; k < 50 && pops8 < p0 + 2; k++) @(posedge clk);
        if (pops8 < p0 + 2) check("scan_timeout", 0, 1);
        #1;
        rst = 1'b1;
        q8.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        repeat (6) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
